// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel-enable divider, h/v counters, registered sync/DE/RGB.
// Optional colour-bar test pattern with input test_mode when VGA_TEST_PATTERN_EN is defined.
module vga_timing_ctrl #(
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [11:0] pixel_data,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        de,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic [9:0]       r_x;
  logic [8:0]       r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic [11:0]      r_rgb;
  logic             r_frame_tick;

  logic             w_pix_ce;
  logic             w_h_wrap;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_de;
  logic             w_hs;
  logic             w_vs;
  logic [11:0]      w_pix;
  logic [11:0]      w_rgb;

  assign w_pix_ce = (r_div == DIV_W'(PIX_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_pix_ce) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_comb begin
    w_h_wrap = (r_h_cnt == 10'(H_TOTAL - 1));
    w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  // Sync/DE are decoded from the pre-increment position and registered one pixel later.
  assign w_de = (r_h_cnt < 10'(H_VIS)) && (r_v_cnt < 10'(V_VIS));
  assign w_hs = !((r_h_cnt >= 10'(H_VIS + H_FP)) &&
                  (r_h_cnt <= 10'(H_VIS + H_FP + H_SYNC - 1)));
  assign w_vs = !((r_v_cnt >= 10'(V_VIS + V_FP)) &&
                  (r_v_cnt <= 10'(V_VIS + V_FP + V_SYNC - 1)));

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VIS / 8;
  logic [2:0] w_bar;
  assign w_bar = 3'(r_h_cnt / 10'(BAR_W));
  // Bar order white..black falls out of inverted index bits: R=~b1, G=~b2, B=~b0.
  assign w_pix = test_mode ? {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}}
                           : pixel_data;
`else
  assign w_pix = pixel_data;
`endif

  assign w_rgb = w_de ? w_pix : 12'h000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_de         <= 1'b0;
      r_rgb        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_pix_ce) begin
        r_h_cnt      <= w_h_next;
        r_v_cnt      <= w_v_next;
        r_x          <= (w_h_next < 10'(H_VIS)) ? w_h_next : 10'd0;
        r_y          <= (w_v_next < 10'(V_VIS)) ? w_v_next[8:0] : 9'd0;
        r_hs         <= w_hs;
        r_vs         <= w_vs;
        r_de         <= w_de;
        r_rgb        <= w_rgb;
        r_frame_tick <= w_h_wrap && (r_v_cnt == 10'(V_VIS - 1));
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign hs         = r_hs;
  assign vs         = r_vs;
  assign de         = r_de;
  assign r          = r_rgb[11:8];
  assign g          = r_rgb[7:4];
  assign b          = r_rgb[3:0];
  assign frame_tick = r_frame_tick;

endmodule
